mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 128 ++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares a single memory port between a fetch requester and a data requester.
// Define MEM_ARB_TIMEOUT_EN to add a 255-cycle wait timeout that raises a sticky err flag.
module mem_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  input  logic        dm_rd,
  input  logic        dm_wr,
  input  logic [15:0] dm_addr,
  input  logic [15:0] dm_wdata,
  output logic        if_done,
  output logic [15:0] if_data,
  output logic        dm_done,
  output logic [15:0] dm_rdata,
  output logic        stall_if,
  output logic        stall_mem,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_done,
  input  logic [15:0] mem_rdata,
  output logic        err
);

  typedef enum logic [2:0] {IDLE, IF_WAIT, DM_WAIT, IF_RESP, DM_RESP} arbState_t;

  arbState_t   stateQ, stateD;
  logic        dmReq, grantDm, grantIf;
  logic        lastGrantDm, dmIsWrite;
  logic        timeout, waitDone;
  logic [15:0] captureData;

  // Fairness: on a conflict the side that did not win last time is granted.
  assign dmReq       = dm_rd | dm_wr;
  assign grantDm     = dmReq & (~if_req | ~lastGrantDm);
  assign grantIf     = if_req & ~grantDm;
  assign waitDone    = mem_done | timeout;
  assign captureData = mem_done ? mem_rdata : 16'h0000;

`ifdef MEM_ARB_TIMEOUT_EN
  logic [7:0] waitCnt;

  assign timeout = (waitCnt == 8'hFF) & ~mem_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      waitCnt <= '0;
      err     <= 1'b0;
    end else begin
      if (stateQ == IF_WAIT || stateQ == DM_WAIT) waitCnt <= waitCnt + 8'd1;
      else                                        waitCnt <= '0;
      if (timeout) err <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stateQ <= IDLE;
    else     stateQ <= stateD;
  end

  // NOTE: the default assignment first keeps this combinational block free of inferred latches.
  always_comb begin
    stateD = stateQ;
    unique case (stateQ)
      IDLE: begin
        if (grantDm)      stateD = DM_WAIT;
        else if (grantIf) stateD = IF_WAIT;
      end
      IF_WAIT: if (waitDone) stateD = IF_RESP;
      DM_WAIT: if (waitDone) stateD = DM_RESP;
      IF_RESP, DM_RESP: stateD = IDLE;
      default: stateD = IDLE;
    endcase
  end

  always_comb begin
    if_done   = (stateQ == IF_RESP);
    dm_done   = (stateQ == DM_RESP);
    stall_if  = if_req & ~if_done;
    stall_mem = dmReq & ~dm_done;
  end

  // Command register: mem_en is a one-cycle pulse in the first wait cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_en      <= 1'b0;
      mem_wr      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      dmIsWrite   <= 1'b0;
      lastGrantDm <= 1'b0;
    end else begin
      mem_en <= 1'b0;
      mem_wr <= 1'b0;
      if (stateQ == IDLE && grantDm) begin
        mem_en      <= 1'b1;
        mem_wr      <= dm_wr;
        mem_addr    <= dm_addr;
        mem_wdata   <= dm_wdata;
        dmIsWrite   <= dm_wr;
        lastGrantDm <= 1'b1;
      end else if (stateQ == IDLE && grantIf) begin
        mem_en      <= 1'b1;
        mem_addr    <= if_addr;
        lastGrantDm <= 1'b0;
      end
    end
  end

  // Captured data persists until the next completion; writes leave dm_rdata alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_data  <= '0;
      dm_rdata <= '0;
    end else begin
      if (stateQ == IF_WAIT && waitDone)               if_data  <= captureData;
      if (stateQ == DM_WAIT && waitDone && !dmIsWrite) dm_rdata <= captureData;
    end
  end

endmodule
